fwd_hazard_ctrl: RTL and testbench



---
 rtl/fwd_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and hazard control for the 5-stage RV64I pipeline: EX/MEM/WB shadow records,
// load-use / memory-wait stall logic. Define FWD_HAZARD_PERF_EN to add saturating stall counters.
module fwd_hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int STALL_CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  input  logic              flush,
  input  logic              mem_stall,
`ifdef FWD_HAZARD_PERF_EN
  output logic [STALL_CNT_W-1:0] lu_stall_cnt,
  output logic [STALL_CNT_W-1:0] mem_stall_cnt,
`endif
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic [1:0]        fsm_state
);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              ld;
  } rec_t;

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    LU_BUBBLE = 2'b01,
    MEM_HOLD  = 2'b10
  } state_t;

  rec_t   ex_rec, mem_rec, wb_rec;
  rec_t   id_rec;
  state_t state;

  logic lu_rs1, lu_rs2, load_use, lu_eff;

  function automatic logic rec_hit(input rec_t r, input logic use_src,
                                   input logic [REG_AW-1:0] src);
    return use_src && (src != '0) && r.v && (r.rd == src);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic use_src, input logic [REG_AW-1:0] src,
                                         input logic lu_hit);
    logic [1:0] sel;
    // NOTE: default first so every path assigns sel and no latch is inferred.
    sel = 2'b00;
    if (lu_hit)                          sel = 2'b00;
    else if (rec_hit(ex_rec,  use_src, src)) sel = 2'b11;
    else if (rec_hit(mem_rec, use_src, src)) sel = 2'b10;
    else if (rec_hit(wb_rec,  use_src, src)) sel = 2'b01;
    return sel;
  endfunction

  // A load in EX cannot supply data yet; that source is a load-use hazard, not a forward.
  assign lu_rs1   = ex_rec.ld && rec_hit(ex_rec, id_use_rs1, id_rs1);
  assign lu_rs2   = ex_rec.ld && rec_hit(ex_rec, id_use_rs2, id_rs2);
  assign load_use = id_valid && (lu_rs1 || lu_rs2);
  assign lu_eff   = load_use && !flush;

  assign forward_a = fwd_sel(id_use_rs1, id_rs1, lu_rs1);
  assign forward_b = fwd_sel(id_use_rs2, id_rs2, lu_rs2);
  assign stall_id  = mem_stall || lu_eff;
  assign bubble_ex = lu_eff && !mem_stall;
  assign fsm_state = state;

  always_comb begin
    id_rec = '0;
    if (id_valid && !stall_id && !flush && id_wr_en && (id_rd != '0)) begin
      id_rec.v  = 1'b1;
      id_rec.rd = id_rd;
      id_rec.ld = id_is_load;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so the three records shift as one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rec  <= '0;
      mem_rec <= '0;
      wb_rec  <= '0;
    end else if (!mem_stall) begin
      wb_rec  <= mem_rec;
      mem_rec <= ex_rec;
      ex_rec  <= id_rec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_stall)   state <= MEM_HOLD;
          else if (lu_eff) state <= LU_BUBBLE;
        end
        LU_BUBBLE: state <= RUN;
        MEM_HOLD:  if (!mem_stall) state <= RUN;
        default:   state <= RUN;
      endcase
    end
  end

`ifdef FWD_HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_stall_cnt  <= '0;
      mem_stall_cnt <= '0;
    end else begin
      if (bubble_ex && (lu_stall_cnt != '1))   lu_stall_cnt  <= lu_stall_cnt + 1'b1;
      if (mem_stall && (mem_stall_cnt != '1))  mem_stall_cnt <= mem_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed self-checking bench for fwd_hazard_ctrl; perf counter checks when FWD_HAZARD_PERF_EN is defined.
module tb_fwd_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_use_rs1, id_use_rs2, id_wr_en, id_is_load, flush, mem_stall;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] forward_a, forward_b, fsm_state;
  logic       stall_id, bubble_ex;
`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] lu_stall_cnt, mem_stall_cnt;
`endif
  int checks = 0;
  int errors = 0;

  fwd_hazard_ctrl #(.REG_AW(5), .STALL_CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .flush(flush), .mem_stall(mem_stall),
`ifdef FWD_HAZARD_PERF_EN
    .lu_stall_cnt(lu_stall_cnt), .mem_stall_cnt(mem_stall_cnt),
`endif
    .forward_a(forward_a), .forward_b(forward_b), .stall_id(stall_id),
    .bubble_ex(bubble_ex), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic w, input logic ld);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_wr_en = w; id_is_load = ld;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nop();
    flush = 1'b0; mem_stall = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    nop();
    flush = 1'b0; mem_stall = 1'b0; rst_n = 1'b0;
    #3;
    checks++; if ({forward_a, forward_b, stall_id, bubble_ex, fsm_state} !== 8'h00) begin
      errors++; $display("FAIL reset_init: got %b want 00000000",
                         {forward_a, forward_b, stall_id, bubble_ex, fsm_state}); end
    @(negedge clk); rst_n = 1'b1; step();
    // Build state: x3 in MEM, load x8 in EX, memory wait for two edges.
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0); step();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1); step();
    drive(1'b1, 5'd8, 5'd3, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    mem_stall = 1'b1; step(); step();
    mem_stall = 1'b0; #1;
    checks++; if ({forward_b, stall_id, bubble_ex, fsm_state} !== 6'b10_1_1_10) begin
      errors++; $display("FAIL reset_prestate: got %b want 101110",
                         {forward_b, stall_id, bubble_ex, fsm_state}); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({forward_a, forward_b, stall_id, bubble_ex, fsm_state} !== 8'h00) begin
      errors++; $display("FAIL reset_async: got %b want 00000000",
                         {forward_a, forward_b, stall_id, bubble_ex, fsm_state}); end
    nop();
    @(negedge clk); rst_n = 1'b1; step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0); step();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0); #1;
    checks++; if ({forward_a, forward_b} !== 4'b1111) begin
      errors++; $display("FAIL b2b_ex: got %b want 1111", {forward_a, forward_b}); end
    checks++; if (stall_id !== 1'b0) begin
      errors++; $display("FAIL b2b_nostall: got %b want 0", stall_id); end

    do_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0); step();
    nop(); step();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0); #1;
    checks++; if ({forward_a, forward_b} !== 4'b1010) begin
      errors++; $display("FAIL b2b_mem: got %b want 1010", {forward_a, forward_b}); end

    do_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0); step();
    nop(); step();
    nop(); step();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0); #1;
    checks++; if ({forward_a, forward_b} !== 4'b0101) begin
      errors++; $display("FAIL b2b_wb: got %b want 0101", {forward_a, forward_b}); end
    id_use_rs2 = 1'b0; #1;
    checks++; if (forward_b !== 2'b00) begin
      errors++; $display("FAIL b2b_unused_rs2: got %b want 00", forward_b); end
  endtask

  task automatic test_priority();
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0); step();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0); step();
    drive(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0); #1;
    checks++; if ({forward_a, forward_b} !== 4'b1111) begin
      errors++; $display("FAIL prio_ex_over_mem: got %b want 1111", {forward_a, forward_b}); end

    do_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1); step();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0); #1;
    checks++; if ({forward_a, forward_b} !== 4'b0000) begin
      errors++; $display("FAIL prio_x0: got %b want 0000", {forward_a, forward_b}); end
    checks++; if ({stall_id, bubble_ex} !== 2'b00) begin
      errors++; $display("FAIL prio_x0_nostall: got %b want 00", {stall_id, bubble_ex}); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1); step();
    drive(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0); #1;
    checks++; if ({stall_id, bubble_ex, forward_a, fsm_state} !== 6'b11_00_00) begin
      errors++; $display("FAIL lu_detect: got %b want 110000",
                         {stall_id, bubble_ex, forward_a, fsm_state}); end
    step();
    checks++; if ({stall_id, bubble_ex, forward_a, fsm_state} !== 6'b00_10_01) begin
      errors++; $display("FAIL lu_resolved: got %b want 001001",
                         {stall_id, bubble_ex, forward_a, fsm_state}); end
`ifdef FWD_HAZARD_PERF_EN
    checks++; if (lu_stall_cnt !== 32'd1) begin
      errors++; $display("FAIL lu_cnt: got %0d want 1", lu_stall_cnt); end
`endif
    step(); nop(); #1;
    checks++; if (fsm_state !== 2'b00) begin
      errors++; $display("FAIL lu_back_to_run: got %b want 00", fsm_state); end
  endtask

  task automatic test_mem_stall();
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0); step();
    nop(); step();
    drive(1'b1, 5'd10, 5'd2, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0);
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({forward_a, stall_id, bubble_ex} !== 4'b10_1_0) begin
        errors++; $display("FAIL memst_hold%0d: got %b want 1010", i,
                           {forward_a, stall_id, bubble_ex}); end
      checks++; if (fsm_state !== ((i == 0) ? 2'b00 : 2'b10)) begin
        errors++; $display("FAIL memst_fsm%0d: got %b want %b", i, fsm_state,
                           (i == 0) ? 2'b00 : 2'b10); end
      step();
    end
    mem_stall = 1'b0; #1;
    checks++; if ({forward_a, stall_id, fsm_state} !== 5'b10_0_10) begin
      errors++; $display("FAIL memst_release: got %b want 10010", {forward_a, stall_id, fsm_state}); end
`ifdef FWD_HAZARD_PERF_EN
    checks++; if (mem_stall_cnt !== 32'd3) begin
      errors++; $display("FAIL memst_cnt: got %0d want 3", mem_stall_cnt); end
`endif
    step(); nop(); #1;
    checks++; if (fsm_state !== 2'b00) begin
      errors++; $display("FAIL memst_back_to_run: got %b want 00", fsm_state); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1); step();
    drive(1'b1, 5'd8, 5'd2, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
    flush = 1'b1; #1;
    checks++; if ({stall_id, bubble_ex} !== 2'b00) begin
      errors++; $display("FAIL flush_lu: got %b want 00", {stall_id, bubble_ex}); end
    step();
    flush = 1'b0; #1;
    checks++; if ({forward_a, stall_id, fsm_state} !== 5'b10_0_00) begin
      errors++; $display("FAIL flush_ex_invalid: got %b want 10000", {forward_a, stall_id, fsm_state}); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_priority();
    test_load_use();
    test_mem_stall();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
